// File: rtl/score_digits_render_if.sv
// Raster, score-control and glyph-ROM signals shared between the score renderer and its surroundings.
interface score_digits_render_if;
    logic [10:0] hpos;
    logic [10:0] vpos;
    logic        video_active;
    logic        vsync;
    logic        inc;
    logic        clr;
    logic [3:0]  rom_digit;
    logic [2:0]  rom_yofs;
    logic [7:0]  rom_bits;
    logic        pixel;
    logic [15:0] score;
    logic [3:0]  pending;
    logic        overflow;

    modport master (
        output hpos, vpos, video_active, vsync, inc, clr, rom_bits,
        input  rom_digit, rom_yofs, pixel, score, pending, overflow
    );

    modport slave (
        input  hpos, vpos, video_active, vsync, inc, clr, rom_bits,
        output rom_digit, rom_yofs, pixel, score, pending, overflow
    );
endinterface

// File: rtl/score_digits_render.sv
// Four-digit BCD score counter applied once per frame, rendered as 2x-scaled glyphs in a 64x16 window.
module score_digits_render #(
    parameter logic [10:0] XPOS = 11'd32,
    parameter logic [10:0] YPOS = 11'd32
) (
    input  logic                  clk,
    input  logic                  reset,
    score_digits_render_if.slave  bus
);
    localparam int unsigned FIELD_W = 64;
    localparam int unsigned FIELD_H = 16;
    localparam int unsigned CW      = 12;

    logic        prev_vsync_q;
    logic [15:0] score_q,    score_d;
    logic [3:0]  pending_q,  pending_d;
    logic        overflow_q, overflow_d;
    logic        pixel_q,    pixel_d;

    logic        frame_tick_c;
    logic        apply_c;
    logic [15:0] score_inc_c;
    logic        score_carry_c;
    logic        in_win_c;
    logic [5:0]  rel_x_c;
    logic [3:0]  rel_y_c;
    logic [2:0]  xofs_c;
    logic [3:0]  rom_digit_c;
    logic [2:0]  rom_yofs_c;

    // BCD +1 across four nibbles; returns {carry_out, sum}
    function automatic logic [16:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (s[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = 4'(s[4*i +: 4] + 4'd1);
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    assign frame_tick_c = prev_vsync_q & ~bus.vsync;
    assign apply_c      = frame_tick_c && (pending_q != 4'd0);
    assign {score_carry_c, score_inc_c} = bcd_inc(score_q);

    always_comb begin
        score_d    = score_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (bus.clr) begin
            score_d    = 16'h0000;
            pending_d  = 4'd0;
            overflow_d = 1'b0;
        end else begin
            if (apply_c) begin
                score_d = score_inc_c;
                if (score_carry_c) overflow_d = 1'b1;
            end
            // inc and an applied frame cancel out, so pending only moves when exactly one fires
            if (bus.inc && !apply_c) begin
                if (pending_q != 4'hF) pending_d = 4'(pending_q + 4'd1);
            end else if (!bus.inc && apply_c) begin
                pending_d = 4'(pending_q - 4'd1);
            end
        end
    end

    // Window decode; wide compares avoid wrap when XPOS/YPOS sit near the 11-bit limit
    always_comb begin
        in_win_c = ({1'b0, bus.hpos} >= {1'b0, XPOS}) &&
                   ({1'b0, bus.hpos} <  CW'({1'b0, XPOS} + CW'(FIELD_W))) &&
                   ({1'b0, bus.vpos} >= {1'b0, YPOS}) &&
                   ({1'b0, bus.vpos} <  CW'({1'b0, YPOS} + CW'(FIELD_H)));
        rel_x_c  = 6'(bus.hpos - XPOS);
        rel_y_c  = 4'(bus.vpos - YPOS);
        xofs_c   = rel_x_c[3:1];
        rom_digit_c = 4'd0;
        rom_yofs_c  = 3'd0;
        if (in_win_c) begin
            rom_yofs_c = rel_y_c[3:1];
            case (rel_x_c[5:4])
                2'd0:    rom_digit_c = score_q[15:12];
                2'd1:    rom_digit_c = score_q[11:8];
                2'd2:    rom_digit_c = score_q[7:4];
                default: rom_digit_c = score_q[3:0];
            endcase
        end
        pixel_d = bus.rom_bits[3'(3'd7 - xofs_c)] & in_win_c & bus.video_active;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_vsync_q <= 1'b0;
            score_q      <= 16'h0000;
            pending_q    <= 4'd0;
            overflow_q   <= 1'b0;
            pixel_q      <= 1'b0;
        end else begin
            prev_vsync_q <= bus.vsync;
            score_q      <= score_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            pixel_q      <= pixel_d;
        end
    end

    assign bus.rom_digit = rom_digit_c;
    assign bus.rom_yofs  = rom_yofs_c;
    assign bus.pixel     = pixel_q;
    assign bus.score     = score_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_score_digits_render.sv
// Directed scoreboard bench for score_digits_render: score counting, BCD carry, saturation, reset, rendering.
module tb_score_digits_render;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    score_digits_render_if bus ();

    score_digits_render #(.XPOS(11'd32), .YPOS(11'd32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 5x5 glyph ROM; rows 5-7 and bits 7-5 read as zero
    function automatic logic [7:0] rom_fn(input logic [3:0] d, input logic [2:0] y);
        logic [24:0] g;
        case (d)
            4'd0: g = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
            4'd1: g = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b01110};
            4'd2: g = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
            4'd3: g = {5'b11111, 5'b00001, 5'b01111, 5'b00001, 5'b11111};
            4'd4: g = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
            4'd5: g = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
            4'd6: g = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
            4'd7: g = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b00100};
            4'd8: g = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
            4'd9: g = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
            default: g = '0;
        endcase
        if (y > 3'd4) return 8'h00;
        return {3'b000, g[24 - 5*int'(y) -: 5]};
    endfunction

    assign bus.rom_bits = rom_fn(bus.rom_digit, bus.rom_yofs);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty observed %0h required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] state_obs();
        return {11'b0, bus.score, bus.pending, bus.overflow};
    endfunction

    task automatic chk_state(input string tag, input logic [15:0] s, input logic [3:0] p, input logic o);
        push(tag, {11'b0, s, p, o});
        pop_chk(state_obs());
    endtask

    task automatic inc_pulse();
        bus.inc = 1'b1;
        tick();
        bus.inc = 1'b0;
    endtask

    task automatic vsync_fall();
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        tick();
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    // One queued increment applied per frame, two clocks per count
    task automatic add_score(input int n);
        for (int i = 0; i < n; i++) begin
            bus.inc   = 1'b1;
            bus.vsync = 1'b1;
            tick();
            bus.inc   = 1'b0;
            bus.vsync = 1'b0;
            tick();
        end
    endtask

    initial begin
        logic [3:0] digs [4];
        int         rel;
        logic [2:0] xo;
        logic [7:0] rowv;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.hpos = '0;
        bus.vpos = '0;
        bus.video_active = 1'b0;
        bus.vsync = 1'b0;
        bus.inc = 1'b0;
        bus.clr = 1'b0;
        #1;
        chk_state("reset_state", 16'h0000, 4'd0, 1'b0);
        push("reset_pixel", 32'd0);
        pop_chk({31'b0, bus.pixel});
        tick();
        tick();
        reset = 1'b0;
        tick();

        repeat (3) inc_pulse();
        chk_state("three_inc", 16'h0000, 4'd3, 1'b0);
        vsync_fall();
        chk_state("fall1", 16'h0001, 4'd2, 1'b0);
        vsync_fall();
        chk_state("fall2", 16'h0002, 4'd1, 1'b0);
        vsync_fall();
        chk_state("fall3", 16'h0003, 4'd0, 1'b0);
        vsync_fall();
        chk_state("fall_no_pending", 16'h0003, 4'd0, 1'b0);

        clr_pulse();
        chk_state("clr1", 16'h0000, 4'd0, 1'b0);
        add_score(9);
        chk_state("score_9", 16'h0009, 4'd0, 1'b0);
        inc_pulse();
        vsync_fall();
        chk_state("carry_9_10", 16'h0010, 4'd0, 1'b0);
        clr_pulse();
        add_score(999);
        chk_state("score_999", 16'h0999, 4'd0, 1'b0);
        add_score(1);
        chk_state("carry_999_1000", 16'h1000, 4'd0, 1'b0);

        clr_pulse();
        add_score(9999);
        chk_state("score_9999", 16'h9999, 4'd0, 1'b0);
        inc_pulse();
        vsync_fall();
        chk_state("wrap_overflow", 16'h0000, 4'd0, 1'b1);
        add_score(1);
        chk_state("overflow_sticky", 16'h0001, 4'd0, 1'b1);
        clr_pulse();
        chk_state("clr_overflow", 16'h0000, 4'd0, 1'b0);

        repeat (20) inc_pulse();
        chk_state("pending_sat", 16'h0000, 4'd15, 1'b0);
        bus.vsync = 1'b1;
        tick();
        bus.inc   = 1'b1;
        bus.vsync = 1'b0;
        tick();
        bus.inc   = 1'b0;
        chk_state("inc_with_tick", 16'h0001, 4'd15, 1'b0);
        bus.vsync = 1'b1;
        tick();
        bus.clr   = 1'b1;
        bus.inc   = 1'b1;
        bus.vsync = 1'b0;
        tick();
        bus.clr   = 1'b0;
        bus.inc   = 1'b0;
        chk_state("clr_overrides", 16'h0000, 4'd0, 1'b0);

        add_score(1234);
        chk_state("score_1234", 16'h1234, 4'd0, 1'b0);
        bus.video_active = 1'b1;
        bus.hpos = 11'd54;
        bus.vpos = 11'd32;
        #1;
        push("rom_addr_54", {25'b0, 4'd2, 3'd0});
        pop_chk({25'b0, bus.rom_digit, bus.rom_yofs});
        push("pixel_54", 32'd1);
        tick();
        pop_chk({31'b0, bus.pixel});
        bus.hpos = 11'd31;
        #1;
        push("rom_addr_31", 32'd0);
        pop_chk({25'b0, bus.rom_digit, bus.rom_yofs});
        push("pixel_31", 32'd0);
        tick();
        pop_chk({31'b0, bus.pixel});
        bus.hpos = 11'd54;
        bus.video_active = 1'b0;
        push("pixel_blank", 32'd0);
        tick();
        pop_chk({31'b0, bus.pixel});
        bus.video_active = 1'b1;
        bus.hpos = 11'd95;
        bus.vpos = 11'd47;
        #1;
        push("rom_addr_corner", {25'b0, 4'd4, 3'd7});
        pop_chk({25'b0, bus.rom_digit, bus.rom_yofs});
        bus.hpos = 11'd96;
        #1;
        push("rom_addr_right", 32'd0);
        pop_chk({25'b0, bus.rom_digit, bus.rom_yofs});
        bus.hpos = 11'd40;
        bus.vpos = 11'd48;
        #1;
        push("rom_addr_below", 32'd0);
        pop_chk({25'b0, bus.rom_digit, bus.rom_yofs});

        // Sweep row rel_y=4 (glyph row 2) across the field plus one column each side
        digs[0] = 4'd1; digs[1] = 4'd2; digs[2] = 4'd3; digs[3] = 4'd4;
        bus.vpos = 11'd36;
        for (int h = 31; h <= 96; h++) begin
            bus.hpos = 11'(h);
            rel = h - 32;
            if (rel < 0 || rel > 63) begin
                push("sweep_px", 32'd0);
            end else begin
                xo   = 3'((rel % 16) / 2);
                rowv = rom_fn(digs[rel / 16], 3'd2);
                push("sweep_px", {31'b0, rowv[7 - int'(xo)]});
            end
            tick();
            pop_chk({31'b0, bus.pixel});
        end

        clr_pulse();
        add_score(42);
        repeat (3) inc_pulse();
        chk_state("pre_reset", 16'h0042, 4'd3, 1'b0);
        bus.hpos = 11'd38;
        bus.vpos = 11'd32;
        push("pre_reset_pixel", 32'd1);
        tick();
        pop_chk({31'b0, bus.pixel});
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_state("async_reset", 16'h0000, 4'd0, 1'b0);
        push("async_reset_pixel", 32'd0);
        pop_chk({31'b0, bus.pixel});
        tick();
        reset = 1'b0;
        bus.vsync = 1'b0;
        inc_pulse();
        tick();
        chk_state("no_tick_after_reset", 16'h0000, 4'd1, 1'b0);
        vsync_fall();
        chk_state("tick_after_reset", 16'h0001, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
